// File: rtl/arch_pkg.sv
// Shared register-file architecture constants and the writeback entry type.
package arch_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  // One pending register-file write: destination index plus data.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // One-hot mask selecting register idx in a scoreboard vector.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries used to queue load results.
// Pointers wrap naturally (DEPTH is a power of two); the count tells full
// from empty when the pointers are equal.
module wb_fifo
  import arch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                push_data,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  // Status flags and guarded push/pop strobes derived from the current occupancy.
  always_comb begin
    full    = (cnt == CNT_FULL);
    empty   = (cnt == CNT_W'(0));
    do_push = push && !full;
    do_pop  = pop && !empty;
    head    = mem_q[rd_ptr];
    count   = cnt;
  end

  // Entry storage; contents need no reset because the count qualifies them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; reset discards everything queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= PTR_W'(0);
      rd_ptr <= PTR_W'(0);
      cnt    <= CNT_W'(0);
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback arbiter: sole writer of the register file. ALU results win the
// write port; load results queue in a FIFO and drain when the ALU is idle,
// or forcibly once the FIFO head has waited STARVE_LIMIT cycles. A busy
// scoreboard tracks registers with outstanding loads.
module reg_writeback #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 3,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_rd,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_rd,
  output logic [(2**ADDR_W)-1:0]   busy,
  output logic                     write_en,
  output logic [ADDR_W-1:0]        RW,
  output logic [DATA_W-1:0]        bus_w,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  import arch_pkg::wb_entry_t;
  import arch_pkg::reg_onehot;

  localparam int NUM_REGS = 2**ADDR_W;
  localparam int AGE_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  wb_entry_t             push_entry;
  wb_entry_t             fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  alu_acc;
  logic                  mem_acc;
  logic                  pop;
  logic                  starve;
  logic [AGE_W-1:0]      age;
  logic [AGE_W-1:0]      age_next;
  logic [NUM_REGS-1:0]   busy_next;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (mem_acc),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Arbitration: readies depend only on registered state, ALU wins unless the head is starving.
  always_comb begin
    starve          = !fifo_empty && (age >= AGE_MAX);
    alu_ready       = !starve;
    mem_ready       = !fifo_full;
    alu_acc         = alu_valid && alu_ready;
    mem_acc         = mem_valid && mem_ready;
    pop             = !alu_acc && !fifo_empty;
    push_entry.rd   = mem_rd;
    push_entry.data = mem_data;
  end

  // Head age: held at zero when empty or popping, otherwise counts up to the limit.
  always_comb begin
    age_next = age;
    if (fifo_empty || pop) begin
      age_next = AGE_W'(0);
    end else if (age < AGE_MAX) begin
      age_next = age + AGE_W'(1);
    end else begin
      age_next = age;
    end
  end

  // Scoreboard update: a pop clears its register, a same-cycle issue sets it back (set wins).
  always_comb begin
    busy_next = busy;
    if (pop) begin
      busy_next = busy_next & ~reg_onehot(fifo_head.rd);
    end else begin
      busy_next = busy_next;
    end
    if (issue_valid) begin
      busy_next = busy_next | reg_onehot(issue_rd);
    end else begin
      busy_next = busy_next;
    end
  end

  // Age and scoreboard state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age  <= AGE_W'(0);
      busy <= NUM_REGS'(0);
    end else begin
      age  <= age_next;
      busy <= busy_next;
    end
  end

  // Register-file write port: ALU result, else FIFO head, else idle (index/data held).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_en <= 1'b0;
      RW       <= ADDR_W'(0);
      bus_w    <= DATA_W'(0);
    end else if (alu_acc) begin
      write_en <= 1'b1;
      RW       <= alu_rd;
      bus_w    <= alu_data;
    end else if (pop) begin
      write_en <= 1'b1;
      RW       <= fifo_head.rd;
      bus_w    <= fifo_head.data;
    end else begin
      write_en <= 1'b0;
    end
  end

endmodule
